// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 keypad column scan, 2-FF row sync, debounce, key encode.
// Optional build macro MULTI_KEY_REJECT_EN rejects multi-row chords.
module keypad_scanner #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_value,
    output logic       key_pressed,
    output logic [2:0] is_sign_key
);

    localparam int CMAX = (SCAN_DIV > DEBOUNCE_CNT) ? SCAN_DIV : DEBOUNCE_CNT;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] SCAN_TC = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEB_TC  = CW'(DEBOUNCE_CNT - 1);

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD,
        RELEASE
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [3:0]    rs_meta;
    logic [3:0]    rs;
    logic [3:0]    cand;
    logic [3:0]    row_low;
    logic [CW-1:0] cnt;
    logic [1:0]    col_idx;
    logic [1:0]    row_sel;
    logic [6:0]    key_code;
    logic          scan_tc;
    logic          deb_tc;
    logic          idle;
    logic          multi;
    logic          match;
    logic          cnt_clr;
    logic          cnt_inc;
    logic          col_adv;
    logic          cand_ld;
    logic          key_ld;
    logic          key_clr;

    function automatic logic [6:0] key_lut(input logic [1:0] r,
                                           input logic [1:0] c);
        unique case ({r, c})
            4'h0:    key_lut = {3'b000, 4'd1};
            4'h1:    key_lut = {3'b000, 4'd2};
            4'h2:    key_lut = {3'b000, 4'd3};
            4'h3:    key_lut = {3'b010, 4'd10};
            4'h4:    key_lut = {3'b000, 4'd4};
            4'h5:    key_lut = {3'b000, 4'd5};
            4'h6:    key_lut = {3'b000, 4'd6};
            4'h7:    key_lut = {3'b100, 4'd11};
            4'h8:    key_lut = {3'b000, 4'd7};
            4'h9:    key_lut = {3'b000, 4'd8};
            4'hA:    key_lut = {3'b000, 4'd9};
            4'hB:    key_lut = {3'b011, 4'd12};
            4'hC:    key_lut = {3'b001, 4'd14};
            4'hD:    key_lut = {3'b000, 4'd0};
            4'hE:    key_lut = {3'b111, 4'd15};
            default: key_lut = {3'b101, 4'd13};
        endcase
    endfunction

    // Rows idle high; sync flops reset to the no-key pattern.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rs_meta <= 4'hF;
            rs      <= 4'hF;
        end else begin
            rs_meta <= row_in;
            rs      <= rs_meta;
        end
    end

    assign col_out = ~(4'b0001 << col_idx);
    assign scan_tc = (cnt == SCAN_TC);
    assign deb_tc  = (cnt == DEB_TC);
    assign idle    = (rs == 4'hF);
    assign row_low = ~rs;

`ifdef MULTI_KEY_REJECT_EN
    assign multi = |(row_low & (row_low - 4'd1));
`else
    assign multi = 1'b0;
`endif

    assign match = (rs == cand) && !multi;

    // Lowest-index low row wins when several rows share the column.
    always_comb begin
        row_sel = 2'd3;
        if (!cand[0])      row_sel = 2'd0;
        else if (!cand[1]) row_sel = 2'd1;
        else if (!cand[2]) row_sel = 2'd2;
    end

    assign key_code = key_lut(row_sel, col_idx);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= SCAN;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            SCAN:     if (scan_tc && !idle) state_nx = DEBOUNCE;
            DEBOUNCE: if (!match)           state_nx = SCAN;
                      else if (deb_tc)      state_nx = HELD;
            HELD:     if (idle || multi)    state_nx = RELEASE;
            RELEASE:  if (idle && deb_tc)   state_nx = SCAN;
            default:                        state_nx = SCAN;
        endcase
    end

    always_comb begin
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        col_adv = 1'b0;
        cand_ld = 1'b0;
        key_ld  = 1'b0;
        key_clr = 1'b0;
        unique case (state)
            SCAN: begin
                if (scan_tc) begin
                    cnt_clr = 1'b1;
                    col_adv = idle;
                    cand_ld = !idle;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            DEBOUNCE: begin
                if (!match) begin
                    cnt_clr = 1'b1;
                    col_adv = 1'b1;
                end else if (deb_tc) begin
                    cnt_clr = 1'b1;
                    key_ld  = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            HELD: cnt_clr = 1'b1;
            RELEASE: begin
                if (!idle) begin
                    cnt_clr = 1'b1;
                end else if (deb_tc) begin
                    cnt_clr = 1'b1;
                    col_adv = 1'b1;
                    key_clr = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: cnt_clr = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt         <= '0;
            col_idx     <= 2'd0;
            cand        <= 4'hF;
            key_value   <= 4'd0;
            is_sign_key <= 3'b000;
            key_pressed <= 1'b0;
        end else begin
            if (cnt_clr)      cnt <= '0;
            else if (cnt_inc) cnt <= cnt + CW'(1);
            if (col_adv) col_idx <= col_idx + 2'd1;
            if (cand_ld) cand <= rs;
            if (key_ld) begin
                key_value   <= key_code[3:0];
                is_sign_key <= key_code[6:4];
                key_pressed <= 1'b1;
            end else if (key_clr) begin
                key_pressed <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: keypad model drives rows from col_out; a monitor
// pops expected key codes from a queue on every key_pressed rise.
module tb_keypad_scanner;

    localparam int SD  = 4;
    localparam int DC  = 8;
    localparam int LAT = 2 + 4 * SD + DC + 1;
    localparam int REL = 2 + DC + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key_value;
    logic       key_pressed;
    logic [2:0] is_sign_key;

    logic [15:0] keys = 16'h0000;
    logic [6:0]  exp_q[$];
    logic [6:0]  exp_e;
    logic [6:0]  held;
    logic        kp_q = 1'b0;
    logic [3:0]  exp_col;
    int          tests = 0;
    int          fails = 0;

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DC)) dut (
        .clk        (clk),
        .rst        (rst),
        .row_in     (row_in),
        .col_out    (col_out),
        .key_value  (key_value),
        .key_pressed(key_pressed),
        .is_sign_key(is_sign_key)
    );

    always #5 clk = ~clk;

    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            kp_q = 1'b0;
        end else begin
            if (key_pressed && !kp_q) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_press: got key %0d class %0d expected none",
                             key_value, is_sign_key);
                end else begin
                    exp_e = exp_q.pop_front();
                    check("key_value", 32'(key_value), 32'(exp_e[3:0]));
                    check("is_sign_key", 32'(is_sign_key), 32'(exp_e[6:4]));
                end
                held = {is_sign_key, key_value};
            end else if (key_pressed) begin
                check("held_stable", 32'({is_sign_key, key_value}), 32'(held));
            end
            kp_q = key_pressed;
        end
    end

    task automatic wait_press(input string name, input int bound);
        int n = 0;
        while (!key_pressed && n < bound + 10) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (!key_pressed || n > bound) begin
            fails++;
            $display("FAIL %s_rise: got %0d cycles expected <= %0d", name, n, bound);
        end
    endtask

    task automatic wait_release(input string name);
        int n = 0;
        while (key_pressed && n < REL + 10) begin
            @(negedge clk);
            n++;
        end
        check({name, "_fall"}, 32'(n), 32'(REL));
    endtask

    task automatic press_release(input string name, input int idx,
                                 input logic [3:0] v, input logic [2:0] cls);
        exp_q.push_back({cls, v});
        keys[idx] = 1'b1;
        wait_press(name, LAT);
        repeat (10) @(negedge clk);
        keys[idx] = 1'b0;
        wait_release(name);
        repeat (6) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // 1: reset values and column rotation
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_col", 32'(col_out), 32'h0000000E);
        check("rst_kp", 32'(key_pressed), 0);
        check("rst_kv", 32'(key_value), 0);
        check("rst_cls", 32'(is_sign_key), 0);
        rst = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 1 || k % 4 == 0) begin
                exp_col = ~(4'b0001 << ((k / 4) % 4));
                check("col_rotate", 32'(col_out), 32'(exp_col));
            end
        end

        // 2: '7' stable, then release with exact fall latency
        exp_q.push_back({3'b000, 4'd7});
        keys[8] = 1'b1;
        wait_press("key7", LAT);
        repeat (40) @(negedge clk);
        keys[8] = 1'b0;
        wait_release("key7");
        check("key7_hold_value", 32'(key_value), 7);
        repeat (6) @(negedge clk);

        // 3: bouncing '5' then stable: a single press
        exp_q.push_back({3'b000, 4'd5});
        for (int i = 0; i < 10; i++) begin
            keys[5] = (i % 2 == 0);
            repeat (3) @(negedge clk);
        end
        keys[5] = 1'b1;
        wait_press("key5", LAT);
        repeat (10) @(negedge clk);
        keys[5] = 1'b0;
        wait_release("key5");
        repeat (6) @(negedge clk);

        // 4: operator keys
        press_release("star", 12, 4'd14, 3'b001);
        press_release("keyA", 3, 4'd10, 3'b010);
        press_release("keyB", 7, 4'd11, 3'b100);
        press_release("hash", 14, 4'd15, 3'b111);

        // 5: '1' and '7' together in column 0
`ifdef MULTI_KEY_REJECT_EN
        keys[0] = 1'b1;
        keys[8] = 1'b1;
        repeat (60) @(negedge clk);
        check("chord_rejected", 32'(key_pressed), 0);
        keys[0] = 1'b0;
        keys[8] = 1'b0;
        repeat (20) @(negedge clk);
`else
        exp_q.push_back({3'b000, 4'd1});
        keys[0] = 1'b1;
        keys[8] = 1'b1;
        wait_press("chord", LAT);
        repeat (10) @(negedge clk);
        keys[0] = 1'b0;
        keys[8] = 1'b0;
        wait_release("chord");
        repeat (6) @(negedge clk);
`endif

        // 6: reset in the middle of debouncing '9'
        n = 0;
        while (col_out != 4'b1101 && n < 40) begin
            @(negedge clk);
            n++;
        end
        keys[10] = 1'b1;
        n = 0;
        while (col_out != 4'b1011 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("reach_col2", 32'(col_out), 32'h0000000B);
        repeat (8) @(negedge clk);
        check("mid_debounce_kp", 32'(key_pressed), 0);
        rst = 1'b0;
        #1;
        check("async_rst_col", 32'(col_out), 32'h0000000E);
        check("async_rst_kv", 32'(key_value), 0);
        check("async_rst_cls", 32'(is_sign_key), 0);
        check("async_rst_kp", 32'(key_pressed), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        exp_q.push_back({3'b000, 4'd9});
        wait_press("key9", LAT);
        repeat (10) @(negedge clk);
        keys[10] = 1'b0;
        wait_release("key9");
        repeat (6) @(negedge clk);

        check("queue_drained", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
